// File: rtl/amstrad_tape_player.sv
// Cassette playback engine: turns a CSW-style RLE pulse stream into the tape_in level.
// Stream bytes are buffered in a small FIFO. Pulse lengths are counted in sample ticks,
// which a fractional accumulator derives from ce_4p. The PPI motor bit gates playback.
module amstrad_tape_player #(
    parameter int unsigned SAMPLE_RATE = 44100,
    parameter int unsigned CE_RATE     = 4000000,
    parameter int unsigned FIFO_AW     = 4,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_4p,
    input  logic       play,
    input  logic       stop,
    input  logic       motor,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tape_in,
    output logic       active,
    output logic       underrun
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXT0,
        S_EXT1,
        S_EXT2,
        S_EXT3,
        S_COUNT
    } state_t;

    state_t state, state_next;

    logic [7:0]       mem [0:DEPTH-1];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, push, pop;
    logic [7:0]       head;

    logic [23:0] acc, acc_next;
    logic [31:0] sum;
    logic        tick;

    logic [31:0] len, len_next;
    logic        toggle, set_underrun;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full && !stop;
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign active     = (state != S_IDLE) && play && motor;

    // FIFO storage; the write address is only advanced on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= in_data;
        end
    end

    // FIFO pointers; stop flushes the buffer and drops any push on the same clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Fractional accumulator: one sample tick per CE_RATE/SAMPLE_RATE enabled ce_4p pulses
    always_comb begin
        sum      = {8'd0, acc} + SAMPLE_RATE;
        tick     = 1'b0;
        acc_next = acc;
        if (ce_4p && play && motor) begin
            if (sum >= CE_RATE) begin
                tick     = 1'b1;
                acc_next = 24'(sum - CE_RATE);
            end else begin
                acc_next = sum[23:0];
            end
        end
    end

    // Stream decoder: fetches short or extended lengths, then counts ticks to the pulse end
    always_comb begin
        state_next   = state;
        len_next     = len;
        pop          = 1'b0;
        toggle       = 1'b0;
        set_underrun = 1'b0;
        case (state)
            S_IDLE: begin
                if (play && !fifo_empty) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (play) begin
                    if (fifo_empty) begin
                        set_underrun = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (head != 8'd0) begin
                            len_next   = {24'd0, head};
                            state_next = S_COUNT;
                        end else begin
                            len_next   = '0;
                            state_next = S_EXT0;
                        end
                    end
                end
            end
            S_EXT0, S_EXT1, S_EXT2: begin
                if (play) begin
                    if (fifo_empty) begin
                        set_underrun = 1'b1;
                    end else begin
                        pop = 1'b1;
                        case (state)
                            S_EXT0:  begin len_next[7:0]   = head; state_next = S_EXT1; end
                            S_EXT1:  begin len_next[15:8]  = head; state_next = S_EXT2; end
                            default: begin len_next[23:16] = head; state_next = S_EXT3; end
                        endcase
                    end
                end
            end
            S_EXT3: begin
                if (play) begin
                    if (fifo_empty) begin
                        set_underrun = 1'b1;
                    end else begin
                        pop            = 1'b1;
                        len_next[31:24] = head;
                        if ({head, len[23:0]} == 32'd0) state_next = S_FETCH;
                        else                            state_next = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (len == 32'd1) begin
                        toggle     = 1'b1;
                        len_next   = '0;
                        state_next = S_FETCH;
                    end else begin
                        len_next = len - 32'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, counters and tape level; stop returns everything to the idle condition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            len      <= '0;
            tape_in  <= INIT_LEVEL;
            underrun <= 1'b0;
        end else if (stop) begin
            state    <= S_IDLE;
            acc      <= '0;
            len      <= '0;
            tape_in  <= INIT_LEVEL;
            underrun <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            len      <= len_next;
            tape_in  <= tape_in ^ toggle;
            underrun <= underrun | set_underrun;
        end
    end

endmodule

// File: tb/tb_amstrad_tape_player.sv
// Directed bench for amstrad_tape_player: a 1:1 rate instance for pulse-level checks
// and a default-rate instance for the long accumulator pulse.
module tb_amstrad_tape_player;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_4p = 1'b0;
    logic       play = 1'b0;
    logic       stop = 1'b0;
    logic       motor = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;

    logic in_ready, tape_in, active, underrun;
    logic in_ready2, tape_in2, active2, underrun2;

    int vec_count  = 0;
    int miss_count = 0;

    typedef enum {OP_PUSH, OP_TICK, OP_WAIT, OP_PLAY, OP_MOTOR, OP_STOP, OP_STOPPUSH} op_t;

    // exp = {tape_in, underrun, active, in_ready} after the operation
    typedef struct {
        op_t        op;
        int         arg;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    amstrad_tape_player #(
        .SAMPLE_RATE(1),
        .CE_RATE(1),
        .FIFO_AW(4),
        .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_4p(ce_4p), .play(play), .stop(stop),
        .motor(motor), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tape_in(tape_in), .active(active), .underrun(underrun)
    );

    amstrad_tape_player dut2 (
        .clk(clk), .reset_n(reset_n), .ce_4p(ce_4p), .play(play), .stop(stop),
        .motor(motor), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .tape_in(tape_in2), .active(active2), .underrun(underrun2)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(op_t op, int arg, logic [3:0] exp, string name);
        vec_t v;
        v.op   = op;
        v.arg  = arg;
        v.exp  = exp;
        v.name = name;
        return v;
    endfunction

    task automatic applyStimulus(input op_t op, input int arg);
        logic [31:0] a;
        a = arg;
        case (op)
            OP_PUSH: begin
                in_data = a[7:0]; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end
            OP_TICK: begin
                repeat (arg) begin
                    ce_4p = 1'b1;
                    @(negedge clk);
                    ce_4p = 1'b0;
                    repeat (7) @(negedge clk);
                end
            end
            OP_WAIT:  repeat (arg) @(negedge clk);
            OP_PLAY:  begin play = a[0];  @(negedge clk); end
            OP_MOTOR: begin motor = a[0]; @(negedge clk); end
            OP_STOP: begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
            end
            OP_STOPPUSH: begin
                stop = 1'b1; in_valid = 1'b1; in_data = a[7:0];
                @(negedge clk);
                stop = 1'b0; in_valid = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {tape_in, underrun, active, in_ready};
    endfunction

    initial begin
        int ce_count;

        // T1: pulses 3 and 2 at one tick per ce_4p, then underrun with active held
        vecs.push_back(mk(OP_PUSH,  3, 4'b0001, "t1_push03"));
        vecs.push_back(mk(OP_PUSH,  2, 4'b0001, "t1_push02"));
        vecs.push_back(mk(OP_MOTOR, 1, 4'b0001, "t1_motor_on"));
        vecs.push_back(mk(OP_PLAY,  1, 4'b0011, "t1_play_on"));
        vecs.push_back(mk(OP_WAIT,  3, 4'b0011, "t1_fetch"));
        vecs.push_back(mk(OP_TICK,  1, 4'b0011, "t1_tick1"));
        vecs.push_back(mk(OP_TICK,  1, 4'b0011, "t1_tick2"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1011, "t1_edge_rise"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1011, "t1_tick4"));
        vecs.push_back(mk(OP_TICK,  1, 4'b0111, "t1_edge_fall_underrun"));
        // T2: extended length 5, then a zero-length extended record
        vecs.push_back(mk(OP_PUSH,  0, 4'b0111, "t2_ext_hdr"));
        vecs.push_back(mk(OP_PUSH,  5, 4'b0111, "t2_ext_b0"));
        vecs.push_back(mk(OP_PUSH,  0, 4'b0111, "t2_ext_b1"));
        vecs.push_back(mk(OP_PUSH,  0, 4'b0111, "t2_ext_b2"));
        vecs.push_back(mk(OP_PUSH,  0, 4'b0111, "t2_ext_b3"));
        vecs.push_back(mk(OP_WAIT,  3, 4'b0111, "t2_ext_loaded"));
        vecs.push_back(mk(OP_TICK,  4, 4'b0111, "t2_four_ticks"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1111, "t2_fifth_tick_edge"));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(OP_PUSH, 0, 4'b1111, "t2_zero_ext"));
        vecs.push_back(mk(OP_PUSH,  2, 4'b1111, "t2_after_zero"));
        vecs.push_back(mk(OP_WAIT,  8, 4'b1111, "t2_zero_no_edge"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1111, "t2_next_tick1"));
        vecs.push_back(mk(OP_TICK,  1, 4'b0111, "t2_next_edge"));
        // T3: pulse 10, motor off after 4 ticks for 100 ce_4p, edge 6 ticks after resume
        vecs.push_back(mk(OP_PUSH, 10, 4'b0111, "t3_push0a"));
        vecs.push_back(mk(OP_WAIT,  3, 4'b0111, "t3_fetch"));
        vecs.push_back(mk(OP_TICK,  4, 4'b0111, "t3_four_ticks"));
        vecs.push_back(mk(OP_MOTOR, 0, 4'b0101, "t3_motor_off"));
        vecs.push_back(mk(OP_TICK,100, 4'b0101, "t3_frozen"));
        vecs.push_back(mk(OP_MOTOR, 1, 4'b0111, "t3_motor_on"));
        vecs.push_back(mk(OP_TICK,  5, 4'b0111, "t3_five_more"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1111, "t3_sixth_edge"));
        // stop: flush, idle, level back to INIT_LEVEL; push on the stop clk dropped
        vecs.push_back(mk(OP_STOP,  0, 4'b0001, "stop_clears"));
        vecs.push_back(mk(OP_STOPPUSH, 3, 4'b0001, "stop_push"));
        vecs.push_back(mk(OP_WAIT,  3, 4'b0001, "stop_push_dropped"));
        vecs.push_back(mk(OP_PUSH,  1, 4'b0001, "first_push01"));
        vecs.push_back(mk(OP_WAIT,  3, 4'b0011, "first_fetch"));
        vecs.push_back(mk(OP_TICK,  1, 4'b1111, "first_edge_high"));
        vecs.push_back(mk(OP_STOP,  0, 4'b0001, "stop_again"));

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", 32'(outs()), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].arg);
            checkOutput(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // T5: fill 16 bytes with play=0, 17th refused, one pop frees a slot
        play = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i + 1); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("t5_full", 32'(in_ready), 32'h0);
        in_data = 8'hAA; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("t5_17th_refused", 32'(in_ready), 32'h0);
        play = 1'b1;
        @(negedge clk);
        @(negedge clk);
        play = 1'b0;
        checkOutput("t5_pop_ready", 32'(in_ready), 32'h1);
        applyStimulus(OP_PUSH, 8'h33);
        checkOutput("t5_refill_full", 32'(in_ready), 32'h0);
        applyStimulus(OP_STOP, 0);
        checkOutput("t5_stop_flush", 32'(in_ready), 32'h1);

        // T6: stop mid-COUNT with tape_in high
        play = 1'b1;
        applyStimulus(OP_PUSH, 1);
        applyStimulus(OP_PUSH, 5);
        applyStimulus(OP_WAIT, 3);
        applyStimulus(OP_TICK, 1);
        applyStimulus(OP_TICK, 2);
        checkOutput("t6_pre_stop", 32'(outs()), 32'hB);
        applyStimulus(OP_STOP, 0);
        checkOutput("t6_stop", 32'(outs()), 32'h1);

        // T6: asynchronous reset mid-COUNT with tape_in high and underrun set
        applyStimulus(OP_PUSH, 1);
        applyStimulus(OP_WAIT, 3);
        applyStimulus(OP_TICK, 1);
        applyStimulus(OP_PUSH, 5);
        applyStimulus(OP_WAIT, 3);
        applyStimulus(OP_TICK, 2);
        checkOutput("t6_pre_reset", 32'(outs()), 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_reset", 32'(outs()), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // T4: default rates, pulse 255 ends on ce_4p number 23129 or 23130
        applyStimulus(OP_STOP, 0);
        applyStimulus(OP_PUSH, 8'hFF);
        applyStimulus(OP_WAIT, 3);
        checkOutput("t4_start_level", 32'(tape_in2), 32'h0);
        ce_count = 0;
        ce_4p = 1'b1;
        while (tape_in2 == 1'b0 && ce_count < 30000) begin
            @(negedge clk);
            ce_count++;
        end
        ce_4p = 1'b0;
        vec_count++;
        if (!(ce_count == 23129 || ce_count == 23130)) begin
            miss_count++;
            $display("[TB] FAIL t4_edge_ce: got %0d ce_4p, expected 23129 or 23130", ce_count);
        end
        checkOutput("t4_level_high", 32'(tape_in2), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
